// File: rtl/ysyx_23060332_lsu_align_pkg.sv
// Shared definitions for the LSU alignment unit.
//   size_e  : access size encoding on req_size (B/H/W/D)
//   state_e : alignment FSM states
//   DEF_MEM_BASE / DEF_MEM_SIZE : default valid data-memory window
package ysyx_23060332_lsu_align_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [31:0] DEF_MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_MEM_SIZE = 32'h0800_0000;

endpackage

// File: rtl/ysyx_23060332_lsu_align_if.sv
// Bus bundle between core, LSU alignment unit and word-aligned data memory.
//   req_*  : core request (valid/ready handshake)
//   resp_* : one-cycle completion pulse back to the core
//   mem_*  : aligned beat request to memory, completed by mem_ack
// slave  : the alignment unit's view
// master : the environment's view (core + memory)
interface ysyx_23060332_lsu_align_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [XLEN-1:0]   req_wdata;

  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  logic              mem_req;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [NB-1:0]     mem_wstrb;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_wen, req_addr, req_size, req_signed, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output req_valid, req_wen, req_addr, req_size, req_signed, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/ysyx_23060332_lsu_lane.sv
// Combinational lane steering for one access.
//   off/size/wdata/sgn : access description
//   lo/hi              : read data of beat0 / beat1 (hi = 0 when not split)
//   wstrb0/1, wdata0/1 : strobes and shifted store data for beat0 / beat1
//   split              : access crosses the bus word boundary
//   rdata              : right-justified, extended load result
module ysyx_23060332_lsu_lane
  import ysyx_23060332_lsu_align_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OW   = $clog2(NB)
) (
  input  logic [OW-1:0]   off,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] wdata,
  input  logic            sgn,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] hi,
  output logic [NB-1:0]   wstrb0,
  output logic [NB-1:0]   wstrb1,
  output logic [XLEN-1:0] wdata0,
  output logic [XLEN-1:0] wdata1,
  output logic            split,
  output logic [XLEN-1:0] rdata
);

  logic [4:0]        nbytes;
  logic [NB-1:0]     bmask;
  logic [2*NB-1:0]   mask2;
  logic [2*XLEN-1:0] data2;
  logic [2*XLEN-1:0] rd2;
  logic [XLEN-1:0]   raw;
  logic              sbit;

  assign nbytes = 5'd1 << size;
  assign split  = (5'(off) + nbytes) > 5'(NB);

  always_comb begin
    unique case (size)
      SIZE_B:  bmask = NB'(1);
      SIZE_H:  bmask = NB'(3);
      SIZE_W:  bmask = NB'(15);
      default: bmask = '1;
    endcase
  end

  // Shift into a double-width window: the low half is beat0, the high half
  // is exactly what spills into beat1 (>> (NB-off) without a special case).
  assign mask2  = {{NB{1'b0}}, bmask} << off;
  assign data2  = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
  assign wstrb0 = mask2[NB-1:0];
  assign wstrb1 = mask2[2*NB-1:NB];
  assign wdata0 = data2[XLEN-1:0];
  assign wdata1 = data2[2*XLEN-1:XLEN];

  assign rd2 = {hi, lo} >> {off, 3'b000};
  assign raw = rd2[XLEN-1:0];

  // Double-word loads fill the whole bus, so no extension bit is needed.
  always_comb begin
    unique case (size)
      SIZE_B:  sbit = sgn & raw[7];
      SIZE_H:  sbit = sgn & raw[15];
      SIZE_W:  sbit = sgn & raw[31];
      default: sbit = 1'b0;
    endcase
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NB; i++)
      rdata[8*i +: 8] = (5'(i) < nbytes) ? raw[8*i +: 8] : {8{sbit}};
  end

endmodule

// File: rtl/ysyx_23060332_lsu_align.sv
// Load/store alignment unit: turns a byte-addressed B/H/W/D access into one
// or two word-aligned memory beats, merges/extends load data, and faults
// out-of-window accesses without touching memory.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request / response / memory beat signals (slave view)
module ysyx_23060332_lsu_align
  import ysyx_23060332_lsu_align_pkg::*;
#(
  parameter  int                XLEN     = 32,
  parameter  int                ADDR_W   = 32,
  parameter  logic [ADDR_W-1:0] MEM_BASE = ADDR_W'(DEF_MEM_BASE),
  parameter  logic [ADDR_W-1:0] MEM_SIZE = ADDR_W'(DEF_MEM_SIZE),
  localparam int                NB       = XLEN / 8,
  localparam int                OW       = $clog2(NB)
) (
  input logic clk,
  input logic rst_n,
  ysyx_23060332_lsu_align_if.slave bus
);

  // Inclusive last valid byte, one bit wider so the window end never wraps.
  localparam logic [ADDR_W:0] LAST = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE} - 1'b1;

  state_e state, state_d;

  logic [OW-1:0]     off_q;
  logic [1:0]        size_q;
  logic              sgn_q, wen_q, err_q;
  logic [XLEN-1:0]   wdata_q, lo_q, hi_q;

  logic              mem_req_q, mem_wen_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [NB-1:0]     mem_wstrb_q;

  logic [4:0]        req_nb;
  logic [ADDR_W:0]   req_end;
  logic              req_err;

  logic [OW-1:0]     l_off;
  logic [1:0]        l_size;
  logic [XLEN-1:0]   l_wdata;
  logic [NB-1:0]     l_wstrb0, l_wstrb1;
  logic [XLEN-1:0]   l_wdata0, l_wdata1, l_rdata;
  logic              l_split;

  // Range check of the incoming request.
  assign req_nb  = 5'd1 << bus.req_size;
  assign req_end = {1'b0, bus.req_addr} + (ADDR_W+1)'(req_nb) - 1'b1;
  assign req_err = (bus.req_addr < MEM_BASE) || (req_end > LAST) ||
                   ((bus.req_size == SIZE_D) && (XLEN == 32));

  // The lane sees the live request in IDLE (to form beat0) and the latched
  // request afterwards (beat1 fields and read merge).
  assign l_off   = (state == IDLE) ? bus.req_addr[OW-1:0] : off_q;
  assign l_size  = (state == IDLE) ? bus.req_size         : size_q;
  assign l_wdata = (state == IDLE) ? bus.req_wdata        : wdata_q;

  ysyx_23060332_lsu_lane #(.XLEN(XLEN)) u_lane (
    .off    (l_off),
    .size   (l_size),
    .wdata  (l_wdata),
    .sgn    (sgn_q),
    .lo     (lo_q),
    .hi     (hi_q),
    .wstrb0 (l_wstrb0),
    .wstrb1 (l_wstrb1),
    .wdata0 (l_wdata0),
    .wdata1 (l_wdata1),
    .split  (l_split),
    .rdata  (l_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (bus.req_valid) state_d = req_err ? RESP : BEAT0;
      BEAT0:   if (bus.mem_ack)   state_d = l_split ? BEAT1 : RESP;
      BEAT1:   if (bus.mem_ack)   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q       <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      wen_q       <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.req_valid) begin
          off_q   <= bus.req_addr[OW-1:0];
          size_q  <= bus.req_size;
          sgn_q   <= bus.req_signed;
          wen_q   <= bus.req_wen;
          wdata_q <= bus.req_wdata;
          err_q   <= req_err;
          lo_q    <= '0;
          hi_q    <= '0;
          if (!req_err) begin
            mem_req_q   <= 1'b1;
            mem_wen_q   <= bus.req_wen;
            mem_addr_q  <= bus.req_addr & ~ADDR_W'(NB-1);
            mem_wstrb_q <= bus.req_wen ? l_wstrb0 : '0;
            mem_wdata_q <= bus.req_wen ? l_wdata0 : '0;
          end
        end
        BEAT0: if (bus.mem_ack) begin
          lo_q <= bus.mem_rdata;
          if (l_split) begin
            mem_addr_q  <= mem_addr_q + ADDR_W'(NB);
            mem_wstrb_q <= wen_q ? l_wstrb1 : '0;
            mem_wdata_q <= wen_q ? l_wdata1 : '0;
          end else begin
            mem_req_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_wstrb_q <= '0;
          end
        end
        BEAT1: if (bus.mem_ack) begin
          hi_q        <= bus.mem_rdata;
          mem_req_q   <= 1'b0;
          mem_wen_q   <= 1'b0;
          mem_wstrb_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) && err_q;
  assign bus.resp_rdata = ((state == RESP) && !wen_q && !err_q) ? l_rdata : '0;

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_ysyx_23060332_lsu_align.sv
module tb_ysyx_23060332_lsu_align;
  import ysyx_23060332_lsu_align_pkg::*;

  logic clk = 1'b0;
  logic rst_n, rst64_n;
  always #5 clk = ~clk;

  ysyx_23060332_lsu_align_if #(.XLEN(32), .ADDR_W(32)) b32 ();
  ysyx_23060332_lsu_align_if #(.XLEN(64), .ADDR_W(32)) b64 ();

  ysyx_23060332_lsu_align #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n),   .bus(b32));
  ysyx_23060332_lsu_align #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst64_n), .bus(b64));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        wen;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata, rd0, rd1;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] w1;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[13];

  // One transaction on the 32-bit unit; memory acks every beat in the cycle
  // it is presented. Latency is counted in cycles after the accept edge.
  task automatic run(input vec_t v);
    int cyc, beats;
    @(negedge clk);
    chk({v.name, " ready"}, b32.req_ready, 1);
    b32.req_valid = 1; b32.req_wen = v.wen; b32.req_addr = v.addr;
    b32.req_size = v.size; b32.req_signed = v.sgn; b32.req_wdata = v.wdata;
    @(negedge clk);
    b32.req_valid = 0;
    cyc = 1; beats = 0;
    while (!b32.resp_valid && cyc < 10) begin
      b32.mem_ack = 0;
      if (b32.mem_req) begin
        chk({v.name, " mem_wen"}, b32.mem_wen, v.wen);
        chk({v.name, " addr"},  b32.mem_addr,  beats == 0 ? v.a0 : v.a1);
        chk({v.name, " strb"},  b32.mem_wstrb, beats == 0 ? v.s0 : v.s1);
        chk({v.name, " wdata"}, b32.mem_wdata, beats == 0 ? v.w0 : v.w1);
        b32.mem_ack = 1;
        b32.mem_rdata = (beats == 0) ? v.rd0 : v.rd1;
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    b32.mem_ack = 0;
    chk({v.name, " resp_valid"}, b32.resp_valid, 1);
    chk({v.name, " latency"}, cyc, v.beats + 1);
    chk({v.name, " beats"}, beats, v.beats);
    chk({v.name, " err"}, b32.resp_err, v.err);
    chk({v.name, " rdata"}, b32.resp_rdata, v.rdata);
    chk({v.name, " mem_req_idle"}, b32.mem_req, 0);
  endtask

  initial begin
    // name, wen, addr, size, sgn, wdata, rd0, rd1, beats, a0, s0, w0, a1, s1, w1, err, rdata
    vt[0]  = '{"lw_al",    0, 32'h8000_0000, 2, 0, 0, 32'hDEAD_BEEF, 0, 1,
               32'h8000_0000, 4'h0, 0, 0, 4'h0, 0, 0, 32'hDEAD_BEEF};
    vt[1]  = '{"lh_spl_s", 0, 32'h8000_0003, 1, 1, 0, 32'hAABB_CCDD, 32'h1122_33F4, 2,
               32'h8000_0000, 4'h0, 0, 32'h8000_0004, 4'h0, 0, 0, 32'hFFFF_F4AA};
    vt[2]  = '{"lh_spl_u", 0, 32'h8000_0003, 1, 0, 0, 32'hAABB_CCDD, 32'h1122_33F4, 2,
               32'h8000_0000, 4'h0, 0, 32'h8000_0004, 4'h0, 0, 0, 32'h0000_F4AA};
    vt[3]  = '{"sw_spl",   1, 32'h8000_0002, 2, 0, 32'h1234_5678, 0, 0, 2,
               32'h8000_0000, 4'hC, 32'h5678_0000, 32'h8000_0004, 4'h3, 32'h0000_1234, 0, 0};
    vt[4]  = '{"lb_low",   0, 32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[5]  = '{"sw_high",  1, 32'h87FF_FFFE, 2, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[6]  = '{"ld_x32",   0, 32'h8000_0000, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[7]  = '{"lb_s",     0, 32'h8000_0001, 0, 1, 0, 32'h1122_8033, 0, 1,
               32'h8000_0000, 4'h0, 0, 0, 0, 0, 0, 32'hFFFF_FF80};
    vt[8]  = '{"lw_top",   0, 32'h87FF_FFFC, 2, 0, 0, 32'h0102_0304, 0, 1,
               32'h87FF_FFFC, 4'h0, 0, 0, 0, 0, 0, 32'h0102_0304};
    vt[9]  = '{"sb_b3",    1, 32'h8000_0003, 0, 0, 32'h0000_007E, 0, 0, 1,
               32'h8000_0000, 4'h8, 32'h7E00_0000, 0, 0, 0, 0, 0};
    vt[10] = '{"lhu_o2",   0, 32'h8000_0002, 1, 0, 0, 32'h8001_1234, 0, 1,
               32'h8000_0000, 4'h0, 0, 0, 0, 0, 0, 32'h0000_8001};
    vt[11] = '{"sh_top",   1, 32'h87FF_FFFF, 1, 0, 32'h0000_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[12] = '{"lbu_o2",   0, 32'h8000_0006, 0, 0, 0, 32'h11F0_2233, 0, 1,
               32'h8000_0004, 4'h0, 0, 0, 0, 0, 0, 32'h0000_00F0};

    b32.req_valid = 0; b32.req_wen = 0; b32.req_addr = 0; b32.req_size = 0;
    b32.req_signed = 0; b32.req_wdata = 0; b32.mem_ack = 0; b32.mem_rdata = 0;
    b64.req_valid = 0; b64.req_wen = 0; b64.req_addr = 0; b64.req_size = 0;
    b64.req_signed = 0; b64.req_wdata = 0; b64.mem_ack = 0; b64.mem_rdata = 0;
    rst_n = 0; rst64_n = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst ready",      b32.req_ready,  1);
    chk("rst resp_valid", b32.resp_valid, 0);
    chk("rst resp_err",   b32.resp_err,   0);
    chk("rst resp_rdata", b32.resp_rdata, 0);
    chk("rst mem_req",    b32.mem_req,    0);
    chk("rst mem_wen",    b32.mem_wen,    0);
    chk("rst mem_addr",   b32.mem_addr,   0);
    chk("rst mem_wdata",  b32.mem_wdata,  0);
    chk("rst mem_wstrb",  b32.mem_wstrb,  0);
    chk("rst64 ready",    b64.req_ready,  1);
    chk("rst64 mem_req",  b64.mem_req,    0);
    rst_n = 1; rst64_n = 1;

    for (int i = 0; i < 13; i++) run(vt[i]);

    // SB 0xA5 at 0x80000005 with ack held off for 3 cycles
    @(negedge clk);
    b32.req_valid = 1; b32.req_wen = 1; b32.req_addr = 32'h8000_0005;
    b32.req_size = 0; b32.req_signed = 0; b32.req_wdata = 32'h0000_00A5;
    @(negedge clk);
    b32.req_valid = 0; b32.req_wdata = 32'hFFFF_FFFF; b32.req_addr = 0;
    for (int k = 0; k < 3; k++) begin
      chk("dly mem_req",   b32.mem_req,   1);
      chk("dly addr",      b32.mem_addr,  32'h8000_0004);
      chk("dly strb",      b32.mem_wstrb, 4'b0010);
      chk("dly wdata",     b32.mem_wdata, 32'h0000_A500);
      chk("dly ready",     b32.req_ready, 0);
      chk("dly resp",      b32.resp_valid, 0);
      @(negedge clk);
    end
    b32.mem_ack = 1;
    @(negedge clk);
    b32.mem_ack = 0;
    chk("dly resp_valid", b32.resp_valid, 1);
    chk("dly resp_err",   b32.resp_err,   0);
    chk("dly resp_rdata", b32.resp_rdata, 0);
    chk("dly mem_req_off", b32.mem_req,   0);
    @(negedge clk);
    chk("dly one_pulse",  b32.resp_valid, 0);
    chk("dly ready_back", b32.req_ready,  1);

    // XLEN=64: signed LW at 0x80000006 split across two 64-bit beats
    @(negedge clk);
    b64.req_valid = 1; b64.req_wen = 0; b64.req_addr = 32'h8000_0006;
    b64.req_size = 2; b64.req_signed = 1;
    @(negedge clk);
    b64.req_valid = 0;
    chk("x64 b0 req",  b64.mem_req,   1);
    chk("x64 b0 addr", b64.mem_addr,  32'h8000_0000);
    chk("x64 b0 wen",  b64.mem_wen,   0);
    b64.mem_ack = 1; b64.mem_rdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    chk("x64 b1 req",  b64.mem_req,   1);
    chk("x64 b1 addr", b64.mem_addr,  32'h8000_0008);
    b64.mem_rdata = 64'h0000_0000_0000_99AA;
    @(negedge clk);
    b64.mem_ack = 0;
    chk("x64 resp",    b64.resp_valid, 1);
    chk("x64 rdata",   b64.resp_rdata, 64'hFFFF_FFFF_99AA_1122);

    // XLEN=64: SW at 0x80000006 strobes, then reset during BEAT1
    @(negedge clk);
    b64.req_valid = 1; b64.req_wen = 1; b64.req_addr = 32'h8000_0006;
    b64.req_size = 2; b64.req_signed = 0; b64.req_wdata = 64'h0000_0000_A1B2_C3D4;
    @(negedge clk);
    b64.req_valid = 0;
    chk("x64s b0 strb",  b64.mem_wstrb, 8'hC0);
    chk("x64s b0 wdata", b64.mem_wdata, 64'hC3D4_0000_0000_0000);
    b64.mem_ack = 1;
    @(negedge clk);
    b64.mem_ack = 0;
    chk("x64s b1 strb",  b64.mem_wstrb, 8'h03);
    chk("x64s b1 wdata", b64.mem_wdata, 64'h0000_0000_0000_A1B2);
    chk("x64s b1 addr",  b64.mem_addr,  32'h8000_0008);
    rst64_n = 0;
    #1;
    chk("x64 rst mem_req", b64.mem_req,    0);
    chk("x64 rst resp",    b64.resp_valid, 0);
    @(negedge clk);
    rst64_n = 1;
    @(negedge clk);
    chk("x64 post ready",   b64.req_ready,  1);
    chk("x64 post resp",    b64.resp_valid, 0);
    chk("x64 post mem_req", b64.mem_req,    0);

    // XLEN=64: aligned LD ignores req_signed
    @(negedge clk);
    b64.req_valid = 1; b64.req_wen = 0; b64.req_addr = 32'h8000_0008;
    b64.req_size = 3; b64.req_signed = 1;
    @(negedge clk);
    b64.req_valid = 0;
    chk("x64 ld strb", b64.mem_wstrb, 8'h00);
    b64.mem_ack = 1; b64.mem_rdata = 64'h8877_6655_4433_2211;
    @(negedge clk);
    b64.mem_ack = 0;
    chk("x64 ld resp",  b64.resp_valid, 1);
    chk("x64 ld err",   b64.resp_err,   0);
    chk("x64 ld rdata", b64.resp_rdata, 64'h8877_6655_4433_2211);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
